// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: receiver states, serial line levels and the parity helper shared by serial_frame_rx
package serial_frame_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  function automatic logic even_parity(input logic [15:0] data);
    return ^data;
  endfunction
endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer: one-cycle tick at the half-bit or full-bit terminal count; restart zeroes the count
module serial_bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic half,
  output logic tick
);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] HALF_TC = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(BIT_CYCLES - 1);
  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  assign tick = cyc_cnt_q == (half ? HALF_TC : FULL_TC);
  assign cyc_cnt_d = (restart || tick) ? '0 : cyc_cnt_q + 1'b1;
  always_ff @(posedge clk) cyc_cnt_q <= reset ? '0 : cyc_cnt_d;
endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: mid-bit sampling serial frame receiver with valid/framing/parity pulses.
// Define SERIAL_FRAME_RX_PARITY_EN to expect an even-parity bit between data and stop.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  state_e            state_q, state_d;
  logic              din_q;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_bad_q, par_bad_d;
  logic              dv_q, dv_d, fe_q, fe_d, pe_q, pe_d;
  logic              tick, restart;
  serial_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .half   (state_q == START),
    .tick   (tick)
  );
  assign restart    = state_d != state_q;
  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign parity_err = PAR_EN & pe_q;
  assign busy       = state_q != IDLE;
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    fe_d      = 1'b0;
    pe_d      = 1'b0;
    case (state_q)
      IDLE: if (din_q == START_BIT) begin
        state_d   = START;
        bit_cnt_d = '0;
        par_bad_d = 1'b0;
      end
      START: if (tick) state_d = (din_q == START_BIT) ? DATA : IDLE;
      DATA: if (tick) begin
        // shifting in from the top leaves the first (LSB) bit at bit 0 after DATA_W samples
        shift_d   = DATA_W'({din_q, shift_q} >> 1);
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) state_d = PAR_EN ? PARITY : STOP;
      end
      PARITY: if (tick) begin
        par_bad_d = din_q != even_parity(16'(shift_q));
        state_d   = STOP;
      end
      STOP: if (tick) begin
        state_d = (din_q == STOP_BIT) ? IDLE : BREAK;
        fe_d    = din_q != STOP_BIT;
        pe_d    = din_q == STOP_BIT && par_bad_q;
        dv_d    = din_q == STOP_BIT && !par_bad_q;
        data_d  = dv_d ? shift_q : data_q;
      end
      BREAK: if (din_q == LINE_IDLE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      din_q     <= LINE_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      par_bad_q <= 1'b0;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      din_q     <= din;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      par_bad_q <= par_bad_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
    end
  end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed frames against hand-derived data, pulse counts and valid latency
module tb_serial_frame_rx;
  localparam int W = 8;
  localparam int B = 4;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = W + 2 + PB;
  localparam int STOP_PT = 1 + B / 2 + (W + 1 + PB) * B - 1;
  // din is first registered one edge after it is driven, and valid follows the stop sample by one clock
  localparam int LAT = STOP_PT + 2;
  logic clk = 1'b0, reset = 1'b1, din = 1'b1;
  logic [W-1:0] data_out;
  logic data_valid, frame_err, parity_err, busy;
  int total = 0, bad = 0, cyc = 0;
  int n_dv = 0, n_fe = 0, n_pe = 0, n_multi = 0, n_wide = 0, dv_cyc = 0;
  int t0, dv0, fe0, pe0;
  logic pdv = 1'b0, pfe = 1'b0, ppe = 1'b0;
  logic [W-1:0] dv_hist[$];
  logic [W+2:0] f;
  serial_frame_rx #(.DATA_W(W), .BIT_CYCLES(B)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    #1;
    if (data_valid) begin
      n_dv++;
      dv_cyc = cyc;
      dv_hist.push_back(data_out);
    end
    if (frame_err) n_fe++;
    if (parity_err) n_pe++;
    if ((data_valid && frame_err) || (data_valid && parity_err) || (frame_err && parity_err)) n_multi++;
    if ((data_valid && pdv) || (frame_err && pfe) || (parity_err && ppe)) n_wide++;
    pdv = data_valid;
    pfe = frame_err;
    ppe = parity_err;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  function automatic logic [W+2:0] mk(input logic [W-1:0] d, input logic stop, input logic pflip);
    logic p;
    p = (^d) ^ pflip;
    return (PB != 0) ? {stop, p, d, 1'b0} : {1'b0, stop, d, 1'b0};
  endfunction
  task automatic drive(input logic [W+2:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      din = fr[i];
      repeat (B) @(negedge clk);
    end
  endtask
  task automatic send(input logic [W-1:0] d, input logic stop, input logic pflip);
    drive(mk(d, stop, pflip), NB);
  endtask
  initial begin
    repeat (10) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulses", n_dv + n_fe + n_pe, 0);
    t0 = cyc;
    send(8'hA5, 1'b1, 1'b0);
    chk("a5_count", n_dv, 1);
    chk("a5_data", 32'(data_out), 'hA5);
    chk("a5_latency", dv_cyc - t0, LAT);
    @(negedge clk);
    chk("a5_busy_after", 32'(busy), 0);
    chk("a5_pulse_len", 32'(data_valid), 0);
    repeat (5) @(negedge clk);
    dv0 = n_dv;
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    chk("b2b_count", n_dv - dv0, 2);
    chk("b2b_first", 32'(dv_hist[dv0]), 'h00);
    chk("b2b_second", 32'(dv_hist[dv0+1]), 'hFF);
    chk("b2b_errs", n_fe + n_pe, 0);
    repeat (5) @(negedge clk);
    dv0 = n_dv;
    fe0 = n_fe;
    din = 1'b0;
    @(negedge clk);
    din = 1'b1;
    @(negedge clk);
    chk("glitch_busy", 32'(busy), 1);
    repeat (10) @(negedge clk);
    chk("glitch_idle", 32'(busy), 0);
    chk("glitch_pulses", (n_dv - dv0) + (n_fe - fe0), 0);
    dv0 = n_dv;
    fe0 = n_fe;
    send(8'h3C, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("brk_busy", 32'(busy), 1);
    din = 1'b1;
    repeat (4) @(negedge clk);
    chk("ferr_count", n_fe - fe0, 1);
    chk("ferr_no_valid", n_dv - dv0, 0);
    chk("ferr_data_kept", 32'(data_out), 'hFF);
    chk("brk_exit", 32'(busy), 0);
    send(8'h12, 1'b1, 1'b0);
    chk("after_brk_count", n_dv - dv0, 1);
    chk("after_brk_data", 32'(data_out), 'h12);
    repeat (3) @(negedge clk);
    dv0 = n_dv;
    fe0 = n_fe;
    pe0 = n_pe;
    f = mk(8'h81, 1'b1, 1'b0);
    drive(f, 5);
    din = f[5];
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_data", 32'(data_out), 0);
    chk("midrst_busy", 32'(busy), 0);
    reset = 1'b0;
    din = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_pulses", (n_dv - dv0) + (n_fe - fe0) + (n_pe - pe0), 0);
    send(8'h81, 1'b1, 1'b0);
    chk("post_rst_count", n_dv - dv0, 1);
    chk("post_rst_data", 32'(data_out), 'h81);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    repeat (3) @(negedge clk);
    dv0 = n_dv;
    pe0 = n_pe;
    send(8'h81, 1'b1, 1'b1);
    chk("par_err_count", n_pe - pe0, 1);
    chk("par_no_valid", n_dv - dv0, 0);
    chk("par_data_kept", 32'(data_out), 'h81);
`endif
    repeat (5) @(negedge clk);
    chk("exclusive", n_multi, 0);
    chk("single_cycle", n_wide, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
